// File: rtl/instr_fetch.sv
// Instruction fetch unit: small program memory plus an issue FSM that
// presents one instruction at a time to the CPU over a valid/ready handshake.
module instr_fetch #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [12:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    input  logic          instr_ready,
    output logic [12:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IW = 13;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [IW-1:0] mem [DEPTH];

    logic          idle_like;
    logic          mem_we;
    logic [AW:0]   len_clamp;
    logic          pc_last;

    // Memory is writable only while nothing is being issued; reset blocks writes.
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign mem_we    = prog_we && reset && idle_like;

    // Program length is clamped to the memory depth so pc can never run off the end.
    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign pc_last   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

    // Program memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        len_d   = len_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = len_clamp;
                    pc_d    = '0;
                    state_d = (len_clamp != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                instr_d = mem[pc_q];
                valid_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    if (pc_last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            pc_d    = '0;
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE);
        done_d = (state_d == S_DONE);
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected issued
// instructions plus directed checks of timing, stalls, stop, reset and writes.
module tb_instr_fetch;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          clk;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [12:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stop;
    logic          instr_ready;
    logic [12:0]   instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [12:0]   instr;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push3();
        sb_q.push_back('{instr: 13'h1604, pc: AW'(0)});
        sb_q.push_back('{instr: 13'h1403, pc: AW'(1)});
        sb_q.push_back('{instr: 13'h068A, pc: AW'(2)});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        int pat[7];
        logic [12:0] prog[3];
        exp_t e;
        pat  = '{0, 1, 0, 1, 0, 1, 0};
        prog = '{13'h1604, 13'h1403, 13'h068A};
        n_checks = 0;
        n_fail   = 0;

        // Monitor: compare each accepted instruction against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (reset && !stop && instr_valid && instr_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_issue", 32'(instr), 32'h0);
                        chk("sb_unexpected_issue_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_instr", 32'(instr), 32'(e.instr));
                        chk("sb_pc", 32'(pc), 32'(e.pc));
                    end
                end
            end
        join_none

        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; stop = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;

        // Full run with ready held high: latency 2, one instruction per 2 cycles.
        push3();
        instr_ready = 1'b1; prog_len = 6'd3; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            start = 1'b0;
            chk("t1_valid_seq", 32'(instr_valid), 32'(pat[i]));
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pc", 32'(pc), 32'd2);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_instr_hold", 32'(instr), 32'h068A);

        // Stall on the second instruction for 5 cycles.
        push3();
        instr_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("t2_first_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            chk("t2_hold_instr", 32'(instr), 32'h1403);
            chk("t2_hold_pc", 32'(pc), 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        chk("t2_adv_valid", 32'(instr_valid), 32'd0);
        chk("t2_adv_pc", 32'(pc), 32'd2);
        wait_done("t2_done");

        // Stop from DONE, then zero-length program.
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("t3_idle_done", 32'(done), 32'd0);
        chk("t3_idle_pc", 32'(pc), 32'd0);
        prog_len = 6'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t3_len0_done", 32'(done), 32'd1);
        chk("t3_len0_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_len0_novalid", 32'(instr_valid), 32'd0);
            tick();
        end

        // Stop and start together during ISSUE: stop wins.
        prog_len = 6'd3; instr_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("t4_in_issue", 32'(instr_valid), 32'd1);
        stop = 1'b1; start = 1'b1;
        tick(); stop = 1'b0; start = 1'b0;
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_pc", 32'(pc), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_instr_hold", 32'(instr), 32'h1604);
        tick();
        chk("t4_still_idle", 32'(busy), 32'd0);

        // Program write during ISSUE must be dropped.
        push3();
        start = 1'b1;
        tick(); start = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = AW'(1); prog_data = 13'h1FFF;
        tick();
        prog_we = 1'b0;
        instr_ready = 1'b1;
        wait_done("t5_done");

        // Reset mid-program, then replay from address 0.
        instr_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_instr", 32'(instr), 32'd0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        push3();
        instr_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        wait_done("t6_done_replay");
        chk("t6_pc_end", 32'(pc), 32'd2);

        // Write and start in the same cycle: the write lands before the fetch.
        sb_q.push_back('{instr: 13'h0AAA, pc: AW'(0)});
        prog_we = 1'b1; prog_addr = AW'(0); prog_data = 13'h0AAA;
        prog_len = 6'd1; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_done("t7_done");
        chk("t7_instr", 32'(instr), 32'h0AAA);
        chk("t7_pc", 32'(pc), 32'd0);

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
